// File: rtl/sram_word_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto the 16-bit DE2 SRAM as two
// half-word phases (low half, then high half), stalling the pipeline via ready.
module sram_word_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [16:0] waddr_r, waddr_s, waddr_in_s;
  logic [31:0] wdata_r, wdata_s;
  logic        write_r, write_s;
  logic        req_s, start_s, last_s, busy_s;
  logic        we_n_r, dq_oe_r;
  logic [15:0] dq_out_r;
  logic [17:0] sram_addr_r;
  logic [31:0] rd_data_r;

  assign req_s      = MEM_R_EN | MEM_W_EN;
  assign start_s    = (state_r == IDLE) & req_s;
  assign last_s     = (cnt_r == CNT_LAST);
  assign waddr_in_s = 17'((addr - 32'(BASE_ADDR)) >> 2);
  assign busy_s     = (state_s == LOW) | (state_s == HIGH);

  // Phase sequencing and per-phase cycle counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s = LOW;
          cnt_s   = 4'd0;
        end else begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end
      end
      LOW: begin
        if (last_s) begin
          state_s = HIGH;
          cnt_s   = 4'd0;
        end else begin
          state_s = LOW;
          cnt_s   = cnt_r + 4'd1;
        end
      end
      HIGH: begin
        if (last_s) begin
          state_s = DONE;
          cnt_s   = 4'd0;
        end else begin
          state_s = HIGH;
          cnt_s   = cnt_r + 4'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Operands come straight from the inputs on the starting edge, else from the latch.
  always_comb begin
    if (start_s) begin
      waddr_s = waddr_in_s;
      wdata_s = wr_data;
      write_s = MEM_W_EN;
    end else begin
      waddr_s = waddr_r;
      wdata_s = wdata_r;
      write_s = write_r;
    end
  end

  // Pin drivers are registered from next-state values so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      waddr_r     <= 17'd0;
      wdata_r     <= 32'd0;
      write_r     <= 1'b0;
      we_n_r      <= 1'b1;
      dq_oe_r     <= 1'b0;
      dq_out_r    <= 16'd0;
      sram_addr_r <= 18'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      waddr_r  <= waddr_s;
      wdata_r  <= wdata_s;
      write_r  <= write_s;
      we_n_r   <= ~(write_s & busy_s & (cnt_s != CNT_LAST));
      dq_oe_r  <= write_s & busy_s;
      dq_out_r <= (state_s == HIGH) ? wdata_s[31:16] : wdata_s[15:0];
      if (busy_s) begin
        sram_addr_r <= {waddr_s, (state_s == HIGH)};
      end else begin
        sram_addr_r <= sram_addr_r;
      end
    end
  end

  // Read halves are sampled on the final cycle of their phase and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= 32'd0;
    end else if (!write_r && last_s && (state_r == LOW)) begin
      rd_data_r[15:0] <= SRAM_DQ;
    end else if (!write_r && last_s && (state_r == HIGH)) begin
      rd_data_r[31:16] <= SRAM_DQ;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign ready     = ((state_r == IDLE) & ~req_s) | (state_r == DONE);
  assign rd_data   = rd_data_r;
  assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'hzzzz;
  assign SRAM_ADDR = sram_addr_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_word_controller.sv
// Self-checking bench for sram_word_controller: directed vectors, corner-case
// sequences and random word traffic compared against a word-level memory model.
module tb_sram_word_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] addr, wr_data;
  logic [31:0] rd_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;

  int checks   = 0;
  int failures = 0;

  // Half-word SRAM model; it drives the bus only while the bench expects a read.
  logic [15:0] sram_mem [0:1023];
  logic        tb_rd_active = 1'b0;
  logic        mem_clr = 1'b1;
  logic [15:0] sram_rd_val;
  assign sram_rd_val = sram_mem[SRAM_ADDR[9:0]];
  assign sram_dq = (tb_rd_active && SRAM_WE_N) ? sram_rd_val : 16'hzzzz;

  // Word-level reference: indexed by word number relative to address 1024.
  logic [31:0] ref_words [0:63];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= 16'h0000;
    end else if (!SRAM_WE_N) begin
      sram_mem[SRAM_ADDR[9:0]] <= sram_dq;
    end
  end

  sram_word_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  typedef struct {
    logic        r_en;
    logic        w_en;
    logic [31:0] a;
    logic [31:0] d;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_we_lo;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Presents a request now and waits (bounded) for ready; inputs are left held.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output int we_lo,
                           output logic [31:0] rd);
    MEM_R_EN = r;
    MEM_W_EN = w;
    addr = a;
    wr_data = d;
    tb_rd_active = r & ~w;
    lat = 0;
    we_lo = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!SRAM_WE_N) we_lo++;
    end while (!ready && lat < 50);
    rd = rd_data;
  endtask

  task automatic go_idle();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    tb_rd_active = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, we_lo, k, op;
    logic [31:0] rd, a, d;
    bit in_done;

    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 32'h0,        2};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b1, 32'hDEADBEEF, 0};
    vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0, 32'h0,        2};
    vecs[3] = '{1'b1, 1'b0, 32'd1032, 32'h0,        1'b1, 32'hA5A55A5A, 0};
    vecs[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b1, 32'h0,        0};
    for (int i = 0; i < 64; i++) ref_words[i] = 32'h0;

    rst = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    addr = 32'h0;
    wr_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("reset_dq_z", {31'd0, dut.dq_oe_r}, 32'd0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_sram_addr", {14'd0, SRAM_ADDR}, 32'h0);
    chk("tied_ctrl", {28'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'h0);
    rst = 1'b0;

    // Directed vectors: write, read-back, write-priority, unwritten word.
    for (int i = 0; i < 5; i++) begin
      do_access(vecs[i].r_en, vecs[i].w_en, vecs[i].a, vecs[i].d, lat, we_lo, rd);
      chk($sformatf("vec%0d_latency", i), lat, 32'd5);
      chk($sformatf("vec%0d_we_cycles", i), we_lo, vecs[i].exp_we_lo);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd_data", i), rd, vecs[i].exp_rd);
      go_idle();
    end
    chk("sram0", {16'd0, sram_mem[0]}, 32'hBEEF);
    chk("sram1", {16'd0, sram_mem[1]}, 32'hDEAD);
    chk("sram4", {16'd0, sram_mem[4]}, 32'h5A5A);
    chk("sram5", {16'd0, sram_mem[5]}, 32'hA5A5);
    ref_words[0] = 32'hDEADBEEF;
    ref_words[2] = 32'hA5A55A5A;

    // Write immediately followed by a read presented during DONE.
    do_access(1'b0, 1'b1, 32'd1028, 32'h12345678, lat, we_lo, rd);
    chk("b2b_write_latency", lat, 32'd5);
    do_access(1'b1, 1'b0, 32'd1028, 32'h0, lat, we_lo, rd);
    chk("b2b_read_latency", lat, 32'd6);
    chk("b2b_read_data", rd, 32'h12345678);
    chk("b2b_sram2", {16'd0, sram_mem[2]}, 32'h5678);
    chk("b2b_sram3", {16'd0, sram_mem[3]}, 32'h1234);
    go_idle();
    ref_words[1] = 32'h12345678;

    // Reset during the HIGH phase of a write to word 10.
    MEM_W_EN = 1'b1;
    addr = 32'd1064;
    wr_data = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_high_addr", {14'd0, SRAM_ADDR}, 32'd21);
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("abort_dq_z", {31'd0, dut.dq_oe_r}, 32'd0);
    chk("abort_low_written", {16'd0, sram_mem[20]}, 32'hF00D);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic on words 16..47 with junk upper address bits and random chaining.
    in_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(16, 47);
      op = $urandom_range(0, 2);
      a  = 32'd1024 + 32'(4 * k) + (32'($urandom_range(0, 7)) << 19);
      d  = $urandom;
      do_access(op != 1, op != 0, a, d, lat, we_lo, rd);
      chk($sformatf("rnd%0d_latency", i), lat, in_done ? 32'd6 : 32'd5);
      if (op == 0) begin
        chk($sformatf("rnd%0d_rd_data", i), rd, ref_words[k]);
        chk($sformatf("rnd%0d_we_cycles", i), we_lo, 32'd0);
      end else begin
        ref_words[k] = d;
        chk($sformatf("rnd%0d_we_cycles", i), we_lo, 32'd2);
      end
      if ($urandom_range(0, 1) == 0) begin
        go_idle();
        in_done = 1'b0;
      end else begin
        in_done = 1'b1;
      end
    end
    go_idle();

    for (int w = 0; w < 48; w++) begin
      if (w < 3 || w >= 16)
        chk($sformatf("mem_word%0d", w), {sram_mem[2*w+1], sram_mem[2*w]}, ref_words[w]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
